// File: rtl/prbs7_checker_x8_if.sv
// ----------------------------------------------------------------------------
// prbs7_checker_x8_if
// Bundles the data-side and status-side signals of the PRBS7 x8 checker.
//   data_i        [7:0]  deserialized word, bit 7 = first serial bit
//   valid_i              data_i qualifier
//   clear_i              synchronous clear of counters / error flags
//   lock_o               high while the checker is locked
//   err_o                one-cycle pulse per errored word while locked
//   err_sticky_o         latched error flag
//   bit_err_cnt_o [CNT_W-1:0] saturating bit-error count
//   word_cnt_o    [CNT_W-1:0] saturating checked-word count
// master: the word source / status consumer.  slave: the checker.
// ----------------------------------------------------------------------------
interface prbs7_checker_x8_if #(
  parameter int unsigned CNT_W = 16
);

  logic [7:0]       data_i;
  logic             valid_i;
  logic             clear_i;
  logic             lock_o;
  logic             err_o;
  logic             err_sticky_o;
  logic [CNT_W-1:0] bit_err_cnt_o;
  logic [CNT_W-1:0] word_cnt_o;

  modport master (
    output data_i,
    output valid_i,
    output clear_i,
    input  lock_o,
    input  err_o,
    input  err_sticky_o,
    input  bit_err_cnt_o,
    input  word_cnt_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    input  clear_i,
    output lock_o,
    output err_o,
    output err_sticky_o,
    output bit_err_cnt_o,
    output word_cnt_o
  );

endinterface

// File: rtl/prbs7_checker_x8.sv
// ----------------------------------------------------------------------------
// prbs7_checker_x8
// Self-synchronizing PRBS7 (x^7+x^6+1) checker for 8-bit deserialized words.
// The previous valid word seeds the prediction of the next one, so no seed
// input is needed. A small FSM (UNLOCKED/SEARCH/LOCKED) qualifies lock, and
// while locked the checker counts checked words and mismatched bits.
// Ports:
//   clk_i     clock, rising edge
//   resetn_i  asynchronous active-low reset
//   bus       prbs7_checker_x8_if.slave (data/valid/clear in, status out)
// Parameters:
//   LOCK_CNT  consecutive matching words needed to lock (2..255)
//   LOSS_CNT  consecutive errored words that drop lock (1..15)
//   CNT_W     width of the saturating counters (must match bus CNT_W)
// ----------------------------------------------------------------------------
module prbs7_checker_x8 #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  prbs7_checker_x8_if.slave  bus
);

  localparam int unsigned MATCH_W = 8;
  localparam int unsigned LOSS_W  = 4;
  localparam int unsigned POP_W   = 4;
  localparam int unsigned SUM_W   = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SEARCH   = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Registers
  state_t             r_state;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [LOSS_W-1:0]  r_loss_cnt;
  logic [7:0]         r_prev;
  logic               r_lock;
  logic               r_err;
  logic               r_err_sticky;
  logic [CNT_W-1:0]   r_bit_err_cnt;
  logic [CNT_W-1:0]   r_word_cnt;

  // Combinational signals
  logic [14:0]        w_h;
  logic [7:0]         w_expected;
  logic [7:0]         w_mismatch;
  logic               w_match;
  logic [POP_W-1:0]   w_popcnt;
  state_t             w_state_nxt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [LOSS_W-1:0]  w_loss_nxt;
  logic               w_count;
  logic               w_err_set;
  logic [SUM_W-1:0]   w_bit_sum;
  logic [CNT_W-1:0]   w_bit_err_nxt;
  logic [CNT_W-1:0]   w_word_nxt;
  logic               w_unused_prev_msb;

  // Only the 7 most recent bits form the LFSR state; the MSB is kept in prev
  // for a complete word history but does not enter the prediction.
  assign w_unused_prev_msb = r_prev[7];

  // Parallel PRBS7 prediction: unroll the recurrence b[t] = b[t-7] ^ b[t-6]
  // over 8 bits, highest index being the oldest bit.
  always_comb begin
    w_h       = '0;
    w_h[14:8] = r_prev[6:0];
    for (int i = 7; i >= 0; i--) begin
      w_h[i] = w_h[i+7] ^ w_h[i+6];
    end
    w_expected = w_h[7:0];
  end

  // Compare; an all-zero word is never a valid PRBS7 word, so it never matches.
  assign w_mismatch = bus.data_i ^ w_expected;
  assign w_match    = (w_mismatch == 8'h00) && (bus.data_i != 8'h00);

  // Number of errored bits in the current word.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < 8; i++) begin
      w_popcnt = w_popcnt + POP_W'(w_mismatch[i]);
    end
  end

  // Lock FSM next-state logic; only valid words advance it.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_loss_nxt  = r_loss_cnt;
    if (bus.valid_i) begin
      case (r_state)
        ST_UNLOCKED: begin
          // First word only seeds prev.
          w_state_nxt = ST_SEARCH;
          w_match_nxt = '0;
          w_loss_nxt  = '0;
        end
        ST_SEARCH: begin
          if (w_match) begin
            if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
              w_loss_nxt  = '0;
            end else begin
              w_match_nxt = r_match_cnt + MATCH_W'(1);
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_loss_nxt = '0;
          end else if (r_loss_cnt == LOSS_W'(LOSS_CNT - 1)) begin
            w_state_nxt = ST_SEARCH;
            w_match_nxt = '0;
            w_loss_nxt  = '0;
          end else begin
            w_loss_nxt = r_loss_cnt + LOSS_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_match_nxt = '0;
          w_loss_nxt  = '0;
        end
      endcase
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state     <= ST_UNLOCKED;
      r_match_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_loss_cnt  <= w_loss_nxt;
    end
  end

  // Word history; keeps following the line in every state.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_prev <= '0;
    end else if (bus.valid_i) begin
      r_prev <= bus.data_i;
    end
  end

  // Statistics qualify on the state before the word, so the word that drops
  // lock is still counted and the word that gains lock is not.
  assign w_count   = bus.valid_i && (r_state == ST_LOCKED);
  assign w_err_set = w_count && !w_match && !bus.clear_i;

  // Saturating accumulators.
  assign w_bit_sum     = SUM_W'(r_bit_err_cnt) + SUM_W'(w_popcnt);
  assign w_bit_err_nxt = (w_bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_bit_sum[CNT_W-1:0];
  assign w_word_nxt    = (r_word_cnt == CNT_MAX) ? CNT_MAX : (r_word_cnt + CNT_W'(1));

  // Status and counter registers; clear takes priority over counting.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_lock        <= 1'b0;
      r_err         <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_bit_err_cnt <= '0;
      r_word_cnt    <= '0;
    end else begin
      r_lock <= (w_state_nxt == ST_LOCKED);
      r_err  <= w_err_set;
      if (bus.clear_i) begin
        r_err_sticky  <= 1'b0;
        r_bit_err_cnt <= '0;
        r_word_cnt    <= '0;
      end else begin
        if (w_err_set) begin
          r_err_sticky <= 1'b1;
        end
        if (w_count) begin
          r_bit_err_cnt <= w_bit_err_nxt;
          r_word_cnt    <= w_word_nxt;
        end
      end
    end
  end

  assign bus.lock_o        = r_lock;
  assign bus.err_o         = r_err;
  assign bus.err_sticky_o  = r_err_sticky;
  assign bus.bit_err_cnt_o = r_bit_err_cnt;
  assign bus.word_cnt_o    = r_word_cnt;

endmodule

// File: tb/tb_prbs7_checker_x8.sv
// ----------------------------------------------------------------------------
// tb_prbs7_checker_x8
// Scoreboard bench: each driven word pushes the expected status for the next
// cycle; an independent monitor pops and compares after every rising edge.
// Narrow counters (CNT_W=4) make saturation reachable.
// ----------------------------------------------------------------------------
module tb_prbs7_checker_x8;

  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic clk_i    = 1'b0;
  logic resetn_i = 1'b0;

  always #5 clk_i = ~clk_i;

  prbs7_checker_x8_if #(.CNT_W(CNT_W)) u_if ();

  prbs7_checker_x8 #(
    .LOCK_CNT (16),
    .LOSS_CNT (4),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .bus      (u_if.slave)
  );

  typedef struct {
    logic lock;
    logic err;
    logic sticky;
    int   bits;
    int   words;
    int   id;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;
  int   e_bits   = 0;
  int   e_words  = 0;
  logic e_lock   = 1'b0;
  logic e_sticky = 1'b0;
  logic [6:0] sh = 7'h7F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int id);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  // Serial-form PRBS7 reference: b[t] = b[t-7] ^ b[t-6], MSB first.
  function automatic logic [7:0] next_word();
    logic [7:0] w;
    logic       b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      b  = sh[6] ^ sh[5];
      sh = {sh[5:0], b};
      w  = {w[6:0], b};
    end
    return w;
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Drive one cycle and record the status expected after the next edge.
  task automatic step(input logic [7:0] d, input logic v, input logic c,
                      input logic lk, input logic er, input int addb, input logic cnt);
    @(negedge clk_i);
    u_if.data_i  = d;
    u_if.valid_i = v;
    u_if.clear_i = c;
    if (c) begin
      e_bits   = 0;
      e_words  = 0;
      e_sticky = 1'b0;
    end else if (v && cnt) begin
      e_bits  = sat(e_bits + addb);
      e_words = sat(e_words + 1);
    end
    if (er) e_sticky = 1'b1;
    e_lock = lk;
    step_id++;
    q.push_back('{lk, er, e_sticky, e_bits, e_words, step_id});
  endtask

  // One seeding word then 16 matching words; lock rises on the last one.
  task automatic relock(input logic [7:0] first);
    step(first, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(next_word(), 1'b1, 1'b0, (k == 16), 1'b0, 0, 1'b0);
    end
  endtask

  task automatic clean(input int n);
    for (int k = 0; k < n; k++) begin
      step(next_word(), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    end
  endtask

  // Flip bits 0 and 3: 2 errors now, 4 more on the next word (0x36 pattern).
  task automatic inject();
    step(next_word() ^ 8'h09, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1);
    step(next_word(),         1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b1);
  endtask

  task automatic check_reset_outputs(input int id);
    chk("rst_lock",   32'(u_if.lock_o),        32'd0, id);
    chk("rst_err",    32'(u_if.err_o),         32'd0, id);
    chk("rst_sticky", 32'(u_if.err_sticky_o),  32'd0, id);
    chk("rst_bits",   32'(u_if.bit_err_cnt_o), 32'd0, id);
    chk("rst_words",  32'(u_if.word_cnt_o),    32'd0, id);
  endtask

  // Monitor: one expected entry per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("lock",   32'(u_if.lock_o),        32'(e.lock),   e.id);
        chk("err",    32'(u_if.err_o),         32'(e.err),    e.id);
        chk("sticky", 32'(u_if.err_sticky_o),  32'(e.sticky), e.id);
        chk("bits",   32'(u_if.bit_err_cnt_o), 32'(e.bits),   e.id);
        chk("words",  32'(u_if.word_cnt_o),    32'(e.words),  e.id);
      end
    end
  end

  initial begin
    logic [7:0] w;
    u_if.data_i  = 8'h00;
    u_if.valid_i = 1'b0;
    u_if.clear_i = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs(0);
    @(negedge clk_i);
    resetn_i = 1'b1;

    // Acquisition from 0xFF, 0x02, 0x0C, ...
    sh = 7'h7F;
    relock(8'hFF);
    clean(5);

    // Valid gaps with junk data: nothing moves during gaps.
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 1)
        step(8'($urandom_range(255)), 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      else
        step(next_word(), 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    end

    // Error injection, driving the 4-bit bit counter into saturation.
    for (int k = 0; k < 3; k++) begin
      inject();
      clean(2);
    end

    // Clear on an errored word wins; the following word still errs.
    step(next_word() ^ 8'h09, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    step(next_word(),         1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b1);
    clean(2);

    // Clear with valid low.
    step(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Four all-zero words drop lock after the fourth.
    w = next_word();
    step(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, $countones(w), 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    relock(next_word());
    clean(3);

    // Asynchronous reset while locked, mid-cycle.
    @(posedge clk_i);
    #3;
    resetn_i = 1'b0;
    #1;
    check_reset_outputs(step_id);
    e_bits   = 0;
    e_words  = 0;
    e_sticky = 1'b0;
    e_lock   = 1'b0;
    @(negedge clk_i);
    u_if.valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    resetn_i = 1'b1;
    relock(next_word());
    clean(2);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(posedge clk_i);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
